// File: rtl/ctx_pkg.sv
// Shared definitions for the context-switch controller: FSM encoding and
// writeback-selector codes seen by the register-file writeback mux.
package ctx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DRAIN   = 3'd1,
      ST_SAVE    = 3'd2,
      ST_WRITE_K = 3'd3,
      ST_LOAD    = 3'd4,
      ST_DONE    = 3'd5
   } state_t;

   localparam logic [2:0] SEL_HILO  = 3'b000;
   localparam logic [2:0] SEL_PCCTX = 3'b111;

endpackage

// File: rtl/ctx_table.sv
// Per-process saved-PC storage. Every slot comes out of reset holding its
// starting PC (slot index times the stride). One write port, async read.
module ctx_table
   import ctx_pkg::*;
#(
   parameter int          NPROC  = 4,
   parameter logic [31:0] STRIDE = 32'h0000_0400,
   localparam int         PW     = $clog2(NPROC)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          we,
   input  logic [PW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [PW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [NPROC];

   // Reset reloads the boot PC of every slot; otherwise single write port.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NPROC; i++) begin
            mem[i] <= 32'(i) * STRIDE;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ctx_switch_ctrl.sv
// Context-switch sequencer: drains the pipeline, saves the running PC into
// the context table and into register KREG, then loads the target's PC.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | normal execution, writeback pass-through, waits for ctx_req
// DRAIN    | fetch stalled, in-flight instruction allowed to retire
// SAVE     | running PC captured into table and pc_contexto
// WRITE_K  | saved PC written to register KREG via selector 111
// LOAD     | PC load strobe with target's saved PC, proc id updated
// DONE     | one-cycle acknowledge, back to IDLE
module ctx_switch_ctrl
   import ctx_pkg::*;
#(
   parameter int          NPROC       = 4,
   parameter logic [4:0]  KREG        = 5'd26,
   parameter logic [31:0] SLOT_STRIDE = 32'h0000_0400,
   localparam int         PW          = $clog2(NPROC)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          ctx_req,
   input  logic [PW-1:0] ctx_target,
   input  logic [31:0]   pc_atual,
   input  logic          halt_ok,
   input  logic          cpu_we,
   input  logic [2:0]    cpu_sel,
   input  logic [4:0]    cpu_rd,
   output logic          reg_we,
   output logic [2:0]    dadoRegControl,
   output logic [4:0]    reg_rd,
   output logic [31:0]   pc_contexto,
   output logic          pc_load,
   output logic [31:0]   pc_novo,
   output logic          stall,
   output logic          ctx_ack,
   output logic [PW-1:0] proc_atual
);

   state_t        state, state_nxt;
   logic [PW-1:0] tgt;
   logic [31:0]   tbl_rdata;

   ctx_table #(
      .NPROC  (NPROC),
      .STRIDE (SLOT_STRIDE)
   ) u_table (
      .clock (clock),
      .reset (reset),
      .we    (state == ST_SAVE),
      .waddr (proc_atual),
      .wdata (pc_atual),
      .raddr (tgt),
      .rdata (tbl_rdata)
   );

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Target is frozen at acceptance; later ctx_target changes are ignored.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                            tgt <= '0;
      else if (state == ST_IDLE && ctx_req)  tgt <= ctx_target;
   end

   // Running process id changes only as the new PC is loaded.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                 proc_atual <= '0;
      else if (state == ST_LOAD)  proc_atual <= tgt;
   end

   // Saved PC held for the writeback selector until the next save.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                 pc_contexto <= '0;
      else if (state == ST_SAVE)  pc_contexto <= pc_atual;
   end

   // Next-state and output decode; writeback defaults to pass-through.
   always_comb begin
      state_nxt      = state;
      reg_we         = cpu_we;
      dadoRegControl = cpu_sel;
      reg_rd         = cpu_rd;
      stall          = 1'b1;
      pc_load        = 1'b0;
      pc_novo        = '0;
      ctx_ack        = 1'b0;
      case (state)
         ST_IDLE: begin
            stall = 1'b0;
            if (ctx_req) begin
               // Switching to ourselves skips the whole save/load sequence.
               state_nxt = (ctx_target != proc_atual) ? ST_DRAIN : ST_DONE;
            end
         end
         ST_DRAIN: begin
            if (halt_ok) state_nxt = ST_SAVE;
         end
         ST_SAVE: begin
            reg_we    = 1'b0;
            state_nxt = ST_WRITE_K;
         end
         ST_WRITE_K: begin
            reg_we         = 1'b1;
            dadoRegControl = SEL_PCCTX;
            reg_rd         = KREG;
            state_nxt      = ST_LOAD;
         end
         ST_LOAD: begin
            reg_we    = 1'b0;
            pc_load   = 1'b1;
            pc_novo   = tbl_rdata;
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            stall     = 1'b0;
            ctx_ack   = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_ctx_switch_ctrl.sv
// Bench for ctx_switch_ctrl: directed scenarios plus random switches, each
// cycle checked against a phase schedule derived from the switch rules and a
// plain array model of the per-process saved PCs.
module tb_ctx_switch_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        ctx_req = 1'b0;
   logic [1:0]  ctx_target = '0;
   logic [31:0] pc_atual = '0;
   logic        halt_ok = 1'b1;
   logic        cpu_we = 1'b0;
   logic [2:0]  cpu_sel = '0;
   logic [4:0]  cpu_rd = '0;
   logic        reg_we;
   logic [2:0]  dadoRegControl;
   logic [4:0]  reg_rd;
   logic [31:0] pc_contexto;
   logic        pc_load;
   logic [31:0] pc_novo;
   logic        stall;
   logic        ctx_ack;
   logic [1:0]  proc_atual;

   int total = 0;
   int bad   = 0;

   // reference model
   logic [31:0] m_tbl [4];
   logic [1:0]  m_proc;
   logic [31:0] m_ctx;

   ctx_switch_ctrl dut (
      .clock          (clock),
      .reset          (reset),
      .ctx_req        (ctx_req),
      .ctx_target     (ctx_target),
      .pc_atual       (pc_atual),
      .halt_ok        (halt_ok),
      .cpu_we         (cpu_we),
      .cpu_sel        (cpu_sel),
      .cpu_rd         (cpu_rd),
      .reg_we         (reg_we),
      .dadoRegControl (dadoRegControl),
      .reg_rd         (reg_rd),
      .pc_contexto    (pc_contexto),
      .pc_load        (pc_load),
      .pc_novo        (pc_novo),
      .stall          (stall),
      .ctx_ack        (ctx_ack),
      .proc_atual     (proc_atual)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_tbl[i] = 32'(i) * 32'h400;
      m_proc = '0;
      m_ctx  = '0;
   endtask

   task automatic rand_cpu();
      cpu_we  = 1'($urandom_range(0, 1));
      cpu_sel = 3'($urandom_range(0, 7));
      cpu_rd  = 5'($urandom_range(0, 31));
   endtask

   task automatic chk_pass(input string tag);
      chk({tag, ".we"},  32'(reg_we),         32'(cpu_we));
      chk({tag, ".sel"}, 32'(dadoRegControl), 32'(cpu_sel));
      chk({tag, ".rd"},  32'(reg_rd),         32'(cpu_rd));
   endtask

   // One complete switch request. Called at a negedge with the DUT in IDLE.
   // Cycle n counts cycles after the accepting edge (n=1 starts at that edge).
   task automatic do_switch(input logic [1:0] t, input int lows, input logic [31:0] pc);
      logic same;
      int   n_save, n_wk, n_load, n_ack;
      same   = (t == m_proc);
      n_save = lows + 2;
      n_wk   = lows + 3;
      n_load = lows + 4;
      n_ack  = same ? 1 : lows + 5;
      pc_atual   = pc;
      ctx_target = t;
      halt_ok    = (lows == 0);
      rand_cpu();
      ctx_req    = 1'b1;
      #1;
      chk("idle.stall", 32'(stall), 32'd0);
      chk_pass("idle");
      for (int n = 1; n <= n_ack + 1; n++) begin
         @(posedge clock);
         #1;
         halt_ok    = (n > lows);
         ctx_target = 2'($urandom_range(0, 3));
         rand_cpu();
         if (n == n_wk && !same) cpu_we = 1'b1;
         @(negedge clock);
         if (n == n_ack + 1) begin
            chk("after.ack", 32'(ctx_ack), 32'd0);
            chk("after.stall", 32'(stall), 32'd0);
            chk_pass("after");
         end else if (n == n_ack) begin
            chk("done.ack", 32'(ctx_ack), 32'd1);
            chk("done.stall", 32'(stall), 32'd0);
            chk("done.load", 32'(pc_load), 32'd0);
            chk("done.proc", 32'(proc_atual), 32'(t));
            chk_pass("done");
            m_proc = t;
         end else if (n <= lows + 1) begin
            chk("drain.stall", 32'(stall), 32'd1);
            chk("drain.ack", 32'(ctx_ack), 32'd0);
            chk("drain.load", 32'(pc_load), 32'd0);
            chk_pass("drain");
         end else if (n == n_save) begin
            chk("save.stall", 32'(stall), 32'd1);
            chk("save.we", 32'(reg_we), 32'd0);
            chk("save.load", 32'(pc_load), 32'd0);
            m_tbl[m_proc] = pc;
            m_ctx = pc;
         end else if (n == n_wk) begin
            chk("wk.stall", 32'(stall), 32'd1);
            chk("wk.we", 32'(reg_we), 32'd1);
            chk("wk.sel", 32'(dadoRegControl), 32'h7);
            chk("wk.rd", 32'(reg_rd), 32'd26);
            chk("wk.pcctx", pc_contexto, m_ctx);
         end else if (n == n_load) begin
            chk("load.stall", 32'(stall), 32'd1);
            chk("load.we", 32'(reg_we), 32'd0);
            chk("load.pcload", 32'(pc_load), 32'd1);
            chk("load.pcnovo", pc_novo, m_tbl[t]);
            chk("load.proc", 32'(proc_atual), 32'(m_proc));
         end
         if (n != n_ack) chk("pcnovo.idle0", pc_novo, (n == n_load && !same) ? m_tbl[t] : 32'd0);
         if (ctx_ack) ctx_req = 1'b0;
      end
      ctx_req = 1'b0;
      chk("pcctx.hold", pc_contexto, m_ctx);
   endtask

   initial begin
      model_reset();
      #12;
      chk("rst.proc",  32'(proc_atual), 32'd0);
      chk("rst.pcctx", pc_contexto, 32'd0);
      chk("rst.ack",   32'(ctx_ack), 32'd0);
      chk("rst.load",  32'(pc_load), 32'd0);
      chk("rst.novo",  pc_novo, 32'd0);
      chk("rst.stall", 32'(stall), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      // boot slot PC of proc 2
      chk("model.slot2", m_tbl[2], 32'h800);
      do_switch(2'd2, 0, $urandom);
      // save/restore round trip through r26
      do_switch(2'd0, 0, $urandom);
      do_switch(2'd1, 0, 32'h1234);
      do_switch(2'd0, 0, $urandom);
      // slow drain
      do_switch(2'd3, 3, $urandom);
      // switch to self
      do_switch(2'd3, 0, $urandom);

      // reset in the middle of WRITE_K
      pc_atual   = 32'hABCD_0000;
      ctx_target = 2'd1;
      halt_ok    = 1'b1;
      ctx_req    = 1'b1;
      cpu_we     = 1'b0;
      for (int n = 1; n <= 3; n++) @(posedge clock);
      #1;
      chk("abort.inwk", 32'(reg_rd), 32'd26);
      reset = 1'b0;
      #1;
      model_reset();
      chk("abort.stall", 32'(stall), 32'd0);
      chk("abort.load",  32'(pc_load), 32'd0);
      chk("abort.novo",  pc_novo, 32'd0);
      chk("abort.ack",   32'(ctx_ack), 32'd0);
      chk("abort.proc",  32'(proc_atual), 32'd0);
      chk("abort.pcctx", pc_contexto, 32'd0);
      chk("abort.we",    32'(reg_we), 32'(cpu_we));
      ctx_req = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      // table reinitialised: slot 3 must be back at its boot PC
      do_switch(2'd3, 0, $urandom);

      for (int k = 0; k < 14; k++) begin
         do_switch(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ctx_switch_ctrl.md
CTX_SWITCH_CTRL -- requirements
Module: ctx_switch_ctrl

Interface
REQ-001 Parameter NPROC, default 4: number of process slots, a power of two ≥2; PW = log2(NPROC).
REQ-002 Parameter KREG, default 5'd26: register receiving the saved PC of the preempted process.
REQ-003 Parameter SLOT_STRIDE, default 32'h0000_0400: initial PC spacing between slots.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-006 ctx_req  in  1  level request for a context switch, held until ctx_ack.
REQ-007 ctx_target  in  PW  process id to switch to, sampled on acceptance only.
REQ-008 pc_atual  in  32  current fetch PC.
REQ-009 halt_ok  in  1  pipeline drained; no instruction still in flight.
REQ-010 cpu_we / cpu_sel / cpu_rd  in  1/3/5  normal writeback request from control unit.
REQ-011 reg_we / dadoRegControl / reg_rd  out  1/3/5  arbitrated writeback port to register file and writeback selector.
REQ-012 pc_contexto  out  32  saved PC driven to writeback selector code 3'b111.
REQ-013 pc_load / pc_novo  out  1/32  one-cycle PC load strobe and new PC value.
REQ-014 stall  out  1  freezes fetch/issue.
REQ-015 ctx_ack  out  1  one-cycle completion pulse.
REQ-016 proc_atual  out  PW  id of the running process.

Function
REQ-017 FSM states: IDLE, DRAIN, SAVE, WRITE_K, LOAD, DONE.
REQ-018 Internal context table: NPROC×32 bits; entry i resets to i*SLOT_STRIDE.
REQ-019 IDLE: pass-through; reg_we=cpu_we, dadoRegControl=cpu_sel, reg_rd=cpu_rd; stall=0.
REQ-020 IDLE with ctx_req=1: latch ctx_target into tgt; if tgt≠proc_atual go DRAIN, else go DONE (no save, no load).
REQ-021 DRAIN: stall=1; writeback still pass-through so in-flight instruction completes; exit to SAVE on first cycle halt_ok=1.
REQ-022 SAVE: stall=1, reg_we=0; table[proc_atual] ← pc_atual; pc_contexto register ← pc_atual.
REQ-023 WRITE_K: stall=1; reg_we=1, dadoRegControl=3'b111, reg_rd=KREG; cpu_we ignored (context engine has priority).
REQ-024 LOAD: stall=1, reg_we=0; pc_load=1, pc_novo=table[tgt]; proc_atual ← tgt.
REQ-025 DONE: ctx_ack=1 for exactly one cycle, stall=0, writeback pass-through; next state IDLE.
REQ-026 Latency: with halt_ok already 1, ctx_ack asserts 5 cycles after the accepting edge; each halt_ok=0 cycle in DRAIN adds 1.
REQ-027 Changes of ctx_target or ctx_req after acceptance are ignored until IDLE.
REQ-028 Requester drops ctx_req in the cycle ctx_ack is seen; ctx_req still high in IDLE is a new request.
REQ-029 pc_contexto holds its last value outside WRITE_K; pc_load=0 and pc_novo=0 outside LOAD.
REQ-030 Process id arithmetic is PW bits; no out-of-range slot is reachable.

Reset
REQ-031 Reset values: state IDLE, proc_atual=0, pc_contexto=0, ctx_ack=0, pc_load=0, pc_novo=0, stall=0, table per REQ-018.
REQ-032 Reset in any state aborts the switch; no partial table update or PC load survives.

Structure
REQ-033 Shared package ctx_pkg holds the state encoding and writeback-selector codes (SEL_HILO=000 … SEL_PCCTX=111).
REQ-034 One sub-module ctx_table: NPROC×32 storage, reset initialisation, one write port, one async read port.

Verification
REQ-035 Reset, NPROC=4: proc_atual=0; switch to 2 -> pc_novo=32'h800, pc_load one cycle, ack 5 cycles after accept.
REQ-036 pc_atual=32'h1234 in proc 0, switch to 1 then back to 0 -> second LOAD pc_novo=32'h1234; WRITE_K writes 32'h1234 to r26 with sel 111.
REQ-037 halt_ok low 3 cycles in DRAIN, cpu_we=1 sel=001 rd=8 -> write passes through; ack at 8 cycles.
REQ-038 ctx_target=proc_atual -> ack next cycle, no pc_load, no reg_we, table unchanged.
REQ-039 reset low during WRITE_K -> outputs at reset values immediately, table reinitialised, no pc_load.
REQ-040 cpu_we=1 forced during WRITE_K -> reg_rd=26, dadoRegControl=111, cpu write dropped.
